// File: rtl/md_unit_pipe.sv
// md_unit_pipe: multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at the start edge and held in pending registers;
// a down-counter models the configured latency before HI/LO are written.
module md_unit_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  input  logic             hilo_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             state_dbg
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_MADD  = 3'b111;

  // state_dbg: 0 = IDLE, 1 = RUN (exported so checkers can follow the FSM)
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  // Arithmetic datapath, all from the operands present at the start edge
  logic [2*WIDTH-1:0] prod_s, prod_u, madd_sum;
  logic               div_signed, neg_a, neg_b, div_by_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, dvd, dvs, dvs_safe;
  logic [WIDTH-1:0]   q_raw, r_raw, quo, rem;

  // Multiply, multiply-accumulate and divide results for the current operands
  always_comb begin
    prod_s   = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
               $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
    prod_u   = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    madd_sum = {hi_q, lo_q} + prod_s;

    // Signed division works on magnitudes; the most-negative value's
    // magnitude is exact as an unsigned number, so MIN / -1 needs no special case.
    div_signed  = (md_op == OP_DIV);
    neg_a       = div_signed & src_a[WIDTH-1];
    neg_b       = div_signed & src_b[WIDTH-1];
    abs_a       = neg_a ? (~src_a + 1'b1) : src_a;
    abs_b       = neg_b ? (~src_b + 1'b1) : src_b;
    dvd         = abs_a;
    dvs         = abs_b;
    div_by_zero = (src_b == '0);
    // Avoid a zero divisor in the datapath; the result is discarded anyway
    dvs_safe    = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
    q_raw       = dvd / dvs_safe;
    r_raw       = dvd % dvs_safe;
    quo         = (neg_a ^ neg_b) ? (~q_raw + 1'b1) : q_raw;
    rem         = neg_a ? (~r_raw + 1'b1) : r_raw;
  end

  // Next-state logic: kill first, then IDLE start decode or RUN countdown
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (kill) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pend_hi_d = '0;
      pend_lo_d = '0;
      pend_wr_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU, OP_MADD: begin
                if (md_op == OP_MULTU)
                  {pend_hi_d, pend_lo_d} = prod_u;
                else if (md_op == OP_MADD)
                  {pend_hi_d, pend_lo_d} = madd_sum;
                else
                  {pend_hi_d, pend_lo_d} = prod_s;
                pend_wr_d = 1'b1;
                cnt_d     = MULT_N;
                state_d   = S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_d = rem;
                pend_lo_d = quo;
                pend_wr_d = ~div_by_zero;
                cnt_d     = DIV_N;
                state_d   = S_RUN;
              end
              OP_MTHI: hi_d = src_a;
              OP_MTLO: lo_d = src_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // start is ignored here; upstream stalls should prevent it
          if (cnt_q <= CNT_ONE) begin
            if (pend_wr_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
            pend_wr_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counter, HI/LO and pending-result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = hilo_sel ? lo_q : hi_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_md_unit_pipe.sv
// Directed bench for md_unit_pipe: default latencies (5/10) plus a second
// instance with MULT_CYCLES=1 and DIV_CYCLES=32 for the latency sweep.
module tb_md_unit_pipe;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_MADD  = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        kill = 1'b0;
  logic        hilo_sel = 1'b0;
  logic        busy, busy2, state_dbg, state_dbg2;
  logic [31:0] hi, lo, rd_data, hi2, lo2, rd_data2;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  md_unit_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .kill(kill), .hilo_sel(hilo_sel),
    .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data), .state_dbg(state_dbg)
  );

  md_unit_pipe #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(32)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .kill(kill), .hilo_sel(hilo_sel),
    .busy(busy2), .hi(hi2), .lo(lo2), .rd_data(rd_data2), .state_dbg(state_dbg2)
  );

  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? busy : busy2;
  endfunction

  function automatic logic [63:0] obs_hilo(input int sel);
    return (sel == 0) ? {hi, lo} : {hi2, lo2};
  endfunction

  function automatic logic [31:0] obs_rd(input int sel);
    return (sel == 0) ? rd_data : rd_data2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: issue one op at a negedge, count busy cycles, optionally kill or
  // inject a stray start mid-flight, then pop the scoreboard and compare HI/LO.
  task automatic do_op(input int sel, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int n_exp, input int kill_at, input int inj_at,
                       input string tag);
    int c;
    logic [63:0] e;
    exp_q.push_back({eh, el});
    md_op = op; src_a = a; src_b = b;
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    kill = (kill_at == 0);
    @(negedge clk);
    start = 1'b0; start2 = 1'b0; kill = 1'b0; md_op = 3'b000;
    c = 0;
    while (obs_busy(sel) && c < 200) begin
      c++;
      if (c == 1) begin
        hilo_sel = 1'b0; #1;
        chk({tag, "_rd_hi_in_run"}, {32'h0, obs_rd(sel)}, {32'h0, m_hi[sel]});
      end
      if (c == 2) begin
        hilo_sel = 1'b1; #1;
        chk({tag, "_rd_lo_in_run"}, {32'h0, obs_rd(sel)}, {32'h0, m_lo[sel]});
      end
      if (c == kill_at) kill = 1'b1;
      if (c == inj_at) begin
        start = 1'b1; md_op = OP_MTLO; src_a = 32'h1234_5678;
      end
      @(negedge clk);
      kill = 1'b0; start = 1'b0; md_op = 3'b000;
    end
    chk({tag, "_busy_cycles"}, 64'(c), 64'(n_exp));
    e = exp_q.pop_front();
    chk({tag, "_hilo"}, obs_hilo(sel), e);
    m_hi[sel] = e[63:32];
    m_lo[sel] = e[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      ps;
    logic [63:0] pu;
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_state", {31'h0, busy, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Async reset mid-cycle with hi=5, lo=7
    do_op(0, OP_MTHI, 32'd5, 32'd0, 32'd5, 32'd0, 0, -1, -1, "mthi5");
    do_op(0, OP_MTLO, 32'd7, 32'd0, 32'd5, 32'd7, 0, -1, -1, "mtlo7");
    #2 reset = 1'b0;
    #1 chk("async_reset", {31'h0, busy, hi}, 64'h0);
    chk("async_reset_lo", {32'h0, lo}, 64'h0);
    #1 reset = 1'b1;
    m_hi[0] = '0; m_lo[0] = '0;
    @(negedge clk);

    // Multiplies
    do_op(0, OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, -1, -1, "mult");
    do_op(0, OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, -1, -1, "multu");

    // Divides, including sign cases and MIN / -1
    do_op(0, OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, -1, -1, "div_m7_2");
    do_op(0, OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, -1, -1, "div_7_m2");
    do_op(0, OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 10, -1, -1, "div_m7_m2");
    do_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, -1, -1, "div_min_m1");
    do_op(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10, -1, -1, "divu");

    // Divide by zero leaves HI/LO untouched but still takes full latency
    do_op(0, OP_MTHI, 32'h11, 32'd0, 32'h11, m_lo[0], 0, -1, -1, "mthi11");
    do_op(0, OP_MTLO, 32'h22, 32'd0, 32'h11, 32'h22, 0, -1, -1, "mtlo22");
    do_op(0, OP_DIV,  32'd99, 32'd0, 32'h11, 32'h22, 10, -1, -1, "div_by_zero");

    // Madd carrying across the LO/HI boundary
    do_op(0, OP_MTHI, 32'h0, 32'd0, 32'h0, 32'h22, 0, -1, -1, "mthi0");
    do_op(0, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'hFFFF_FFFF, 0, -1, -1, "mtloff");
    do_op(0, OP_MADD, 32'd1, 32'd1, 32'd1, 32'd0, 5, -1, -1, "madd_carry");
    do_op(0, OP_MADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 5, -1, -1, "madd_neg");

    // Kill on the 4th busy cycle, and kill on the start edge
    do_op(0, OP_DIV,  32'd100, 32'd7, m_hi[0], m_lo[0], 4, 4, -1, "kill_div");
    do_op(0, OP_MULT, 32'd5, 32'd5, m_hi[0], m_lo[0], 0, 0, -1, "kill_at_start");

    // mthi visible next cycle, busy never rises
    do_op(0, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, m_lo[0], 0, -1, -1, "mthi_dead");

    // Stray mtlo start while RUN is ignored
    do_op(0, OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5, -1, 2, "inj_mtlo");

    // Random multiplies against a 64-bit reference
    for (int i = 0; i < 3; i++) begin
      ra = $urandom(); rb = $urandom_range(32'hFFFF_FFFF, 0);
      ps = longint'($signed(ra)) * longint'($signed(rb));
      do_op(0, OP_MULT, ra, rb, ps[63:32], ps[31:0], 5, -1, -1, "rand_mult");
      pu = 64'(ra) * 64'(rb);
      do_op(0, OP_MULTU, ra, rb, pu[63:32], pu[31:0], 5, -1, -1, "rand_multu");
    end

    // Latency sweep on the second instance
    do_op(1, OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1, -1, -1, "sweep_mult1");
    do_op(1, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32, -1, -1, "sweep_div32");
    chk("sweep_dut1_untouched", {hi, lo}, {m_hi[0], m_lo[0]});

    // Back-to-back: a start on the cycle after completion is accepted
    do_op(0, OP_MULTU, 32'd10, 32'd10, 32'd0, 32'd100, 5, -1, -1, "b2b_first");
    do_op(0, OP_MULTU, 32'd7, 32'd7, 32'd0, 32'd49, 5, -1, -1, "b2b_second");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
